// File: rtl/rstctrl_pkg.sv
// rstctrl_pkg: state encodings, cause codes and reset masks shared by the reset sequencer, software and benches.
package rstctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_HOLD, S_REL, S_OFF} state_e;
  typedef enum logic [2:0] {
    CAUSE_POR    = 3'd0,
    CAUSE_PWROFF = 3'd1,
    CAUSE_WRESET = 3'd2,
    CAUSE_CRESET = 3'd3,
    CAUSE_RRESET = 3'd4
  } cause_e;
  localparam logic [1:0] PAIR_PWROFF = 2'b01;
  localparam logic [1:0] PAIR_WRESET = 2'b10;
  localparam logic [1:0] PAIR_CRESET = 2'b11;
  // Domain reset masks, bit order {cpu, dev, ram, devtbl}
  localparam logic [3:0] MASK_ALL    = 4'b1111;
  localparam logic [3:0] MASK_WRESET = 4'b1101;
  localparam logic [3:0] MASK_RRESET = 4'b1000;
  function automatic logic [3:0] hold_mask(input cause_e c);
    return c == CAUSE_WRESET ? MASK_WRESET : c == CAUSE_RRESET ? MASK_RRESET : MASK_ALL;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/rstctrl.sv
// rstctrl: reset/power sequencer; stretches POR, drains the system, then asserts and
// releases CPU/device/RAM/device-table resets per request type.
module rstctrl
  import rstctrl_pkg::*;
#(
  parameter int HOLDCYCLES   = 16,
  parameter int RELDLY       = 4,
  parameter int DRAINTIMEOUT = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rst0_i,
  input  logic       rst1_i,
  input  logic       rst2_i,
  input  logic       quiesce_ack_i,
  output logic       quiesce_o,
  output logic       cpu_rst_o,
  output logic       dev_rst_o,
  output logic       ram_rst_o,
  output logic       devtbl_rst_o,
  output logic       pwroff_o,
  output logic       busy_o,
  output logic       timeout_o,
  output logic [2:0] cause_o
);
  localparam int CNTBITSZ = $clog2(max3(HOLDCYCLES, RELDLY, DRAINTIMEOUT)) + 1;
  localparam logic [CNTBITSZ-1:0] HOLD_END  = CNTBITSZ'(HOLDCYCLES - 1);
  localparam logic [CNTBITSZ-1:0] REL_END   = CNTBITSZ'(RELDLY - 1);
  localparam logic [CNTBITSZ-1:0] DRAIN_END = CNTBITSZ'(DRAINTIMEOUT - 1);
  if (HOLDCYCLES < 1 || RELDLY < 1 || DRAINTIMEOUT < 1) begin : g_bad_param
    $fatal(1, "rstctrl: HOLDCYCLES, RELDLY and DRAINTIMEOUT must be >= 1");
  end
  state_e state_q, state_d;
  cause_e cause_q, cause_d, req_cause;
  logic [CNTBITSZ-1:0] cnt_q, cnt_d;
  logic [3:0] rst_q, rst_d;
  logic quiesce_q, quiesce_d, pwroff_q, pwroff_d, timeout_q, timeout_d, busy_q, busy_d;
  logic [1:0] pair;
  logic req, drain_done;
  assign pair = {rst1_i, rst0_i};
  // A non-zero level pair takes priority over a coincident rst2 pulse
  assign req_cause = pair == PAIR_PWROFF ? CAUSE_PWROFF :
                     pair == PAIR_WRESET ? CAUSE_WRESET :
                     pair == PAIR_CRESET ? CAUSE_CRESET : CAUSE_RRESET;
  assign req = (|pair) | rst2_i;
  assign drain_done = quiesce_ack_i || cnt_q == DRAIN_END;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d = cnt_q + 1'b1;
    rst_d = rst_q;
    quiesce_d = quiesce_q;
    pwroff_d = pwroff_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = S_DRAIN;
        cause_d = req_cause;
        quiesce_d = 1'b1;
      end
      S_DRAIN: if (drain_done) begin
        state_d = cause_q == CAUSE_PWROFF ? S_OFF : S_HOLD;
        rst_d = cause_q == CAUSE_PWROFF ? MASK_ALL : hold_mask(cause_q);
        pwroff_d = pwroff_q | (cause_q == CAUSE_PWROFF);
        timeout_d = timeout_q | ~quiesce_ack_i;
        quiesce_d = 1'b0;
      end
      S_HOLD: if (cnt_q == HOLD_END) begin
        state_d = S_REL;
        rst_d = {rst_q[3], 3'b000};
      end
      S_REL: if (cnt_q == REL_END) begin
        state_d = S_IDLE;
        rst_d = '0;
      end
      default: rst_d = MASK_ALL;
    endcase
    // The counter only runs in DRAIN/HOLD/REL and restarts on every state change
    cnt_d = (state_d != state_q || state_q == S_IDLE || state_q == S_OFF) ? '0 : cnt_d;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_HOLD;
      cause_q <= CAUSE_POR;
      cnt_q <= '0;
      rst_q <= MASK_ALL;
      quiesce_q <= 1'b0;
      pwroff_q <= 1'b0;
      timeout_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
      rst_q <= rst_d;
      quiesce_q <= quiesce_d;
      pwroff_q <= pwroff_d;
      timeout_q <= timeout_d;
      busy_q <= busy_d;
    end
  end
  assign {cpu_rst_o, dev_rst_o, ram_rst_o, devtbl_rst_o} = rst_q;
  assign quiesce_o = quiesce_q;
  assign pwroff_o = pwroff_q;
  assign timeout_o = timeout_q;
  assign busy_o = busy_q;
  assign cause_o = cause_q;
endmodule

// File: tb/tb_rstctrl.sv
// tb_rstctrl: directed checks of the reset sequencer with DRAINTIMEOUT shortened to 8.
module tb_rstctrl;
  logic clk = 1'b0, rst = 1'b0, rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0, ack = 1'b0;
  logic quiesce, cpu_rst, dev_rst, ram_rst, devtbl_rst, pwroff, busy, timeout;
  logic [2:0] cause;
  logic [3:0] rsts, stat;
  int errors = 0, checks = 0;
  rstctrl #(.HOLDCYCLES(16), .RELDLY(4), .DRAINTIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst), .rst0_i(rst0), .rst1_i(rst1), .rst2_i(rst2),
    .quiesce_ack_i(ack), .quiesce_o(quiesce), .cpu_rst_o(cpu_rst), .dev_rst_o(dev_rst),
    .ram_rst_o(ram_rst), .devtbl_rst_o(devtbl_rst), .pwroff_o(pwroff), .busy_o(busy),
    .timeout_o(timeout), .cause_o(cause)
  );
  always #5 clk = ~clk;
  // {cpu, dev, ram, devtbl} and {quiesce, pwroff, busy, timeout}
  assign rsts = {cpu_rst, dev_rst, ram_rst, devtbl_rst};
  assign stat = {quiesce, pwroff, busy, timeout};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #2 rst = 1'b1;
    tick();
    checks++; if (rsts !== 4'b1111) begin errors++; $display("FAIL por_asserted rsts got %b want 1111", rsts); end
    checks++; if (stat !== 4'b0010) begin errors++; $display("FAIL por_asserted stat got %b want 0010", stat); end
    checks++; if (cause !== 3'd0) begin errors++; $display("FAIL por_cause got %0d want 0", cause); end
    rst = 1'b0;
    repeat (15) tick();
    checks++; if (rsts !== 4'b1111) begin errors++; $display("FAIL por_edge15 rsts got %b want 1111", rsts); end
    tick();
    checks++; if (rsts !== 4'b1000) begin errors++; $display("FAIL por_edge16 rsts got %b want 1000", rsts); end
    repeat (3) tick();
    checks++; if (rsts !== 4'b1000) begin errors++; $display("FAIL por_edge19 rsts got %b want 1000", rsts); end
    tick();
    checks++; if (rsts !== 4'b0000) begin errors++; $display("FAIL por_edge20 rsts got %b want 0000", rsts); end
    checks++; if (stat !== 4'b0000) begin errors++; $display("FAIL por_idle stat got %b want 0000", stat); end
  endtask
  task automatic test_wreset;
    {rst1, rst0} = 2'b10;
    tick();
    checks++; if (stat !== 4'b1010) begin errors++; $display("FAIL wr_accept stat got %b want 1010", stat); end
    checks++; if (cause !== 3'd2) begin errors++; $display("FAIL wr_cause got %0d want 2", cause); end
    tick();
    checks++; if (quiesce !== 1'b1) begin errors++; $display("FAIL wr_drain quiesce got %b want 1", quiesce); end
    tick();
    ack = 1'b1;
    {rst1, rst0} = 2'b00;
    tick();
    ack = 1'b0;
    checks++; if (stat !== 4'b0010) begin errors++; $display("FAIL wr_hold stat got %b want 0010", stat); end
    checks++; if (rsts !== 4'b1101) begin errors++; $display("FAIL wr_hold rsts got %b want 1101", rsts); end
    repeat (15) tick();
    checks++; if (rsts !== 4'b1101) begin errors++; $display("FAIL wr_hold_end rsts got %b want 1101", rsts); end
    tick();
    checks++; if (rsts !== 4'b1000) begin errors++; $display("FAIL wr_rel rsts got %b want 1000", rsts); end
    repeat (3) tick();
    checks++; if (rsts !== 4'b1000) begin errors++; $display("FAIL wr_rel_end rsts got %b want 1000", rsts); end
    tick();
    checks++; if ({rsts, busy} !== 5'b00000) begin errors++; $display("FAIL wr_idle rsts/busy got %b want 00000", {rsts, busy}); end
  endtask
  task automatic test_creset_timeout;
    {rst1, rst0} = 2'b11;
    tick();
    {rst1, rst0} = 2'b00;
    checks++; if (cause !== 3'd3) begin errors++; $display("FAIL cr_cause got %0d want 3", cause); end
    repeat (7) tick();
    checks++; if (stat !== 4'b1010) begin errors++; $display("FAIL cr_drain7 stat got %b want 1010", stat); end
    tick();
    checks++; if (stat !== 4'b0011) begin errors++; $display("FAIL cr_timeout stat got %b want 0011", stat); end
    checks++; if (rsts !== 4'b1111) begin errors++; $display("FAIL cr_hold rsts got %b want 1111", rsts); end
    repeat (20) tick();
    checks++; if ({rsts, stat} !== 8'b0000_0001) begin errors++; $display("FAIL cr_idle rsts/stat got %b want 00000001", {rsts, stat}); end
  endtask
  task automatic test_rreset;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    checks++; if (cause !== 3'd4) begin errors++; $display("FAIL rr_cause got %0d want 4", cause); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (rsts !== 4'b1000) begin errors++; $display("FAIL rr_hold rsts got %b want 1000", rsts); end
    repeat (16) tick();
    checks++; if (rsts !== 4'b1000) begin errors++; $display("FAIL rr_rel rsts got %b want 1000", rsts); end
    repeat (4) tick();
    checks++; if ({rsts, busy} !== 5'b00000) begin errors++; $display("FAIL rr_idle rsts/busy got %b want 00000", {rsts, busy}); end
  endtask
  task automatic test_back_to_back;
    {rst1, rst0} = 2'b11;
    rst2 = 1'b1;
    tick();
    {rst1, rst0} = 2'b00;
    rst2 = 1'b0;
    checks++; if (cause !== 3'd3) begin errors++; $display("FAIL b2b_cause got %0d want 3", cause); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (rsts !== 4'b1111) begin errors++; $display("FAIL b2b_hold rsts got %b want 1111", rsts); end
    tick();
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    repeat (18) tick();
    checks++; if ({rsts, busy} !== 5'b00000) begin errors++; $display("FAIL b2b_idle rsts/busy got %b want 00000", {rsts, busy}); end
    repeat (5) tick();
    checks++; if ({busy, quiesce, cause} !== 5'b00011) begin errors++; $display("FAIL b2b_no_retrigger busy/quiesce/cause got %b want 00011", {busy, quiesce, cause}); end
  endtask
  task automatic test_pwroff;
    {rst1, rst0} = 2'b01;
    tick();
    checks++; if (cause !== 3'd1) begin errors++; $display("FAIL off_cause got %0d want 1", cause); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if ({rsts, stat} !== 8'b1111_0111) begin errors++; $display("FAIL off_entry rsts/stat got %b want 11110111", {rsts, stat}); end
    repeat (1000) tick();
    checks++; if ({rsts, stat} !== 8'b1111_0111) begin errors++; $display("FAIL off_parked rsts/stat got %b want 11110111", {rsts, stat}); end
    {rst1, rst0} = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++; if ({rsts, stat} !== 8'b1111_0010) begin errors++; $display("FAIL off_async_rst rsts/stat got %b want 11110010", {rsts, stat}); end
    checks++; if (cause !== 3'd0) begin errors++; $display("FAIL off_rst_cause got %0d want 0", cause); end
    tick();
    rst = 1'b0;
    repeat (20) tick();
    checks++; if ({rsts, stat} !== 8'b0000_0000) begin errors++; $display("FAIL off_recover rsts/stat got %b want 00000000", {rsts, stat}); end
  endtask
  initial begin
    test_reset();
    test_wreset();
    test_creset_timeout();
    test_rreset();
    test_back_to_back();
    test_pwroff();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
